// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: per-core request/response bundle plus the shared DRAM port
interface dram_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    core_req;
    logic [NCORES-1:0]    core_wen;
    logic [NCORES*AW-1:0] core_addr;
    logic [NCORES*DW-1:0] core_wdata;
    logic [NCORES-1:0]    core_done;
    logic [DW-1:0]        core_rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_dout;
    logic                 mem_wren;
    logic [DW-1:0]        mem_din;

    modport slave (
        input  core_req, core_wen, core_addr, core_wdata, mem_din,
        output core_done, core_rdata, mem_addr, mem_dout, mem_wren
    );

    modport master (
        output core_req, core_wen, core_addr, core_wdata, mem_din,
        input  core_done, core_rdata, mem_addr, mem_dout, mem_wren
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter granting one core at a time onto the shared DRAM, one access per 3 cycles
module dram_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input logic           CLK,
    input logic           rst,
    dram_arbiter_if.slave bus
);
    localparam int IW = $clog2(NCORES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d, idx_q, idx_d, win;
    logic              wen_q, wen_d, wren_q, wren_d, found;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     dout_q, dout_d, rdata_q, rdata_d;
    logic [NCORES-1:0] done_q, done_d, elig;

    assign bus.core_done  = done_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_dout   = dout_q;
    assign bus.mem_wren   = wren_q;

    // Pick the first eligible core after the last winner; the core being acknowledged is masked out
    always_comb begin
        elig  = bus.core_req & ~done_q;
        found = 1'b0;
        win   = '0;
        for (int k = NCORES; k >= 1; k--) begin
            if (elig[IW'((int'(last_q) + k) % NCORES)]) begin
                found = 1'b1;
                win   = IW'((int'(last_q) + k) % NCORES);
            end
        end
    end

    // Next-state and registered-output logic: latch winner in IDLE, drive DRAM in ISSUE, complete in WAIT
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        wren_d  = 1'b0;
        done_d  = '0;
        case (state_q)
            IDLE: if (found) begin
                idx_d   = win;
                last_d  = win;
                wen_d   = bus.core_wen[win];
                wren_d  = bus.core_wen[win];
                addr_d  = bus.core_addr[int'(win)*AW +: AW];
                dout_d  = bus.core_wdata[int'(win)*DW +: DW];
                state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                done_d[idx_q] = 1'b1;
                rdata_d       = wen_q ? rdata_q : bus.mem_din;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset restarts priority at core 0
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NCORES - 1);
            idx_q   <= '0;
            wen_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter with a registered DRAM model
module tb_dram_arbiter;
    typedef struct {int cyc; logic [7:0] addr; logic wen; logic [7:0] data;} acc_t;
    typedef struct {int cyc; int core; logic load; logic [7:0] data;} cmp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         c;
    logic [7:0] exp_rdata;
    logic [3:0] hold;
    logic       pl_en;
    logic [7:0] pl_a, pl_d;
    logic [7:0] mem [256];
    acc_t       aq[$];
    cmp_t       dq[$];

    dram_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) bus ();

    dram_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time expectations
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM: registered address/data/wren, q one cycle after the address edge
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_dout;
        bus.mem_din <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_acc(input int cy, input logic [7:0] a, input logic w, input logic [7:0] d);
        acc_t e;
        e.cyc = cy; e.addr = a; e.wen = w; e.data = d;
        aq.push_back(e);
    endtask

    task automatic exp_done(input int cy, input int k, input logic ld, input logic [7:0] d);
        cmp_t e;
        e.cyc = cy; e.core = k; e.load = ld; e.data = d;
        dq.push_back(e);
    endtask

    task automatic req(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.core_req[k]         = 1'b1;
        bus.core_wen[k]         = w;
        bus.core_addr[k*8 +: 8] = a;
        bus.core_wdata[k*8 +: 8] = d;
    endtask

    task automatic step();
        acc_t a;
        cmp_t e;
        @(negedge clk);
        if (aq.size() != 0 && aq[0].cyc == cyc) begin
            a = aq.pop_front();
            chk("mem_addr", 32'(bus.mem_addr), 32'(a.addr));
            chk("mem_wren", 32'(bus.mem_wren), 32'(a.wen));
            if (a.wen) chk("mem_dout", 32'(bus.mem_dout), 32'(a.data));
        end else if (bus.mem_wren === 1'b1) chk("spurious_wren", 32'(bus.mem_wren), 32'(0));
        if (dq.size() != 0 && dq[0].cyc == cyc) begin
            e = dq.pop_front();
            chk("core_done", 32'(bus.core_done), 32'(1) << e.core);
            if (e.load) exp_rdata = e.data;
            chk(e.load ? "rdata" : "rdata_hold", 32'(bus.core_rdata), 32'(exp_rdata));
        end else if ((bus.core_done !== 4'b0) && (bus.core_done !== 4'bx)) chk("spurious_done", 32'(bus.core_done), 32'(0));
        for (int k = 0; k < 4; k++)
            if (bus.core_done[k] === 1'b1 && !hold[k]) bus.core_req[k] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] pa [5];
        logic [7:0] pd [5];
        pa = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
        pd = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; pl_en = 1'b0; pl_a = 8'h0; pl_d = 8'h0; hold = 4'b0; exp_rdata = 8'h0;
        bus.core_req = '0; bus.core_wen = '0; bus.core_addr = '0; bus.core_wdata = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            pl_en = 1'b1; pl_a = pa[i]; pl_d = pd[i];
            step();
        end
        pl_en = 1'b0;
        for (int k = 0; k < 4; k++) req(k, 1'b0, 8'(k + 1), 8'h0);
        drain(2);
        chk("rst_done", 32'(bus.core_done), 32'(0));
        chk("rst_rdata", 32'(bus.core_rdata), 32'(0));
        chk("rst_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_dout", 32'(bus.mem_dout), 32'(0));
        chk("rst_wren", 32'(bus.mem_wren), 32'(0));
        rst = 1'b0;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_acc(c + 1 + 3*k, 8'(k + 1), 1'b0, 8'h0);
            exp_done(c + 3 + 3*k, k, 1'b1, pd[k + 1]);
        end
        drain(14);
        req(0, 1'b0, 8'h10, 8'h0); c = cyc;
        exp_acc(c + 1, 8'h10, 1'b0, 8'h0); exp_done(c + 3, 0, 1'b1, 8'hA5);
        drain(5);
        req(2, 1'b1, 8'h80, 8'h3C); c = cyc;
        exp_acc(c + 1, 8'h80, 1'b1, 8'h3C); exp_done(c + 3, 2, 1'b0, 8'h0);
        drain(5);
        req(2, 1'b0, 8'h80, 8'h0); c = cyc;
        exp_acc(c + 1, 8'h80, 1'b0, 8'h0); exp_done(c + 3, 2, 1'b1, 8'h3C);
        drain(5);
        req(1, 1'b0, 8'h02, 8'h0); req(3, 1'b0, 8'h04, 8'h0); c = cyc;
        exp_acc(c + 1, 8'h04, 1'b0, 8'h0); exp_done(c + 3, 3, 1'b1, 8'h44);
        exp_acc(c + 4, 8'h02, 1'b0, 8'h0); exp_done(c + 6, 1, 1'b1, 8'h22);
        drain(8);
        hold[1] = 1'b1;
        req(1, 1'b0, 8'h03, 8'h0); c = cyc;
        exp_acc(c + 1, 8'h03, 1'b0, 8'h0); exp_done(c + 3, 1, 1'b1, 8'h33);
        exp_acc(c + 5, 8'h03, 1'b0, 8'h0); exp_done(c + 7, 1, 1'b1, 8'h33);
        drain(4);
        hold[1] = 1'b0;
        drain(6);
        req(3, 1'b1, 8'h90, 8'h5A); c = cyc;
        exp_acc(c + 1, 8'h90, 1'b1, 8'h5A);
        step();
        rst = 1'b1; bus.core_req[3] = 1'b0;
        step();
        chk("rst_mid_done", 32'(bus.core_done), 32'(0));
        chk("rst_mid_wren", 32'(bus.mem_wren), 32'(0));
        rst = 1'b0; exp_rdata = 8'h0;
        req(0, 1'b0, 8'h90, 8'h0); c = cyc;
        exp_acc(c + 1, 8'h90, 1'b0, 8'h0); exp_done(c + 3, 0, 1'b1, 8'h5A);
        drain(6);
        chk("acc_left", 32'(aq.size()), 32'(0));
        chk("done_left", 32'(dq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
